radix4_feeder: RTL and testbench
================================

RADIX4_FEEDER -- requirements
Module: radix4_feeder

Interface
REQ-001 NBITS, default 16, sample and twiddle word width; signed 8.8 fixed point at NBITS=16.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  feeder accepts a sample this cycle.
REQ-007 in_re, in_im  input  NBITS each  signed complex input sample, natural order x[0..15].
REQ-008 out_valid  output  1  group on A..D/W* outputs is valid this cycle.
REQ-009 out_first  output  1  high with the first group (k=0) of each frame.
REQ-010 Ar, Ai, Br, Bi, Cr, Ci, Dr, Di  output  NBITS each  butterfly operands.
REQ-011 WBr, WBi, WCr, WCi, WDr, WDi  output  NBITS each  twiddles for B, C, D.

Function
REQ-012 Frame: 16 complex samples; transfer occurs when in_valid && in_ready at a rising clk edge.
REQ-013 Storage: 16-entry complex buffer written at index wr_cnt (4-bit), which increments per transfer and wraps 15->0.
REQ-014 FSM states: FILL and ISSUE; reset state FILL.
REQ-015 FILL: in_ready=1; the transfer with wr_cnt=15 moves the FSM to ISSUE on the same edge.
REQ-016 ISSUE: in_ready=0; emits groups k=0,1,2,3 on 4 consecutive cycles with no gaps and no backpressure; after k=3 the FSM returns to FILL.
REQ-017 Group k: A=x[k], B=x[k+4], C=x[k+8], D=x[k+12].
REQ-018 Twiddles from a 16-entry constant ROM: W^m = round(256*cos(2*pi*m/16)) - j*round(256*sin(2*pi*m/16)); WB=W^k, WC=W^(2k), WD=W^(3k), with exponents taken mod 16.
REQ-019 ROM values: cos terms 256, 237, 181, 98, 0 for m=0..4, with quadrant symmetry for the remaining entries; W^0 = 256+j0.
REQ-020 All outputs are registered; group k appears 1 cycle after its ISSUE cycle begins, so the first out_valid follows the 16th transfer by 2 edges.
REQ-021 out_first=1 only with k=0; A..W outputs hold their last values while out_valid=0.
REQ-022 in_valid asserted while in_ready=0: no transfer, and wr_cnt and the buffer are unchanged.
REQ-023 Data are passed through unmodified (no scaling or rounding); the ROM is the only arithmetic source.

Reset
REQ-024 rst_n low asynchronously sets: FSM=FILL, wr_cnt=0, issue counter=0, out_valid=0, out_first=0, all A..D and W* outputs=0.
REQ-025 While rst_n=0, in_ready is 0; after release it is 1 from the first edge.
REQ-026 Reset mid-FILL or mid-ISSUE discards the partial frame; the first post-reset transfer is x[0].
REQ-027 Buffer contents need no reset.

Configuration
REQ-028 Macro RADIX4_FEEDER_PINGPONG_EN.
REQ-029 Defined: two 16-entry banks; FILL of one bank proceeds while the other bank ISSUEs. in_ready=0 only when both banks hold unissued frames; issue order is strict frame order; a continuous stream at one sample/cycle runs without stalls.
REQ-030 Undefined: single bank, behaviour exactly per REQ-014..REQ-022.

Verification
REQ-031 Reset, then 16 transfers with x[n]=(n*256)+j0 -> 2 edges later, 4 valid cycles: k=0 A=0, B=1024, C=2048, D=3072, out_first=1, WB=WC=WD=256+j0.
REQ-032 Same frame, cycle k=1 -> A=256, B=1280, WBr=237, WBi=-98, WCr=181, WCi=-181, WDr=98, WDi=-237.
REQ-033 in_valid held high continuously, macro undefined -> in_ready low for exactly the ISSUE cycles after each 16th sample; second frame output matches its input.
REQ-034 rst_n pulsed low after 9 transfers -> all outputs 0 immediately; a new 16-sample frame issues correctly.
REQ-035 in_valid toggling randomly -> the group contents depend only on the accepted samples.
REQ-036 Macro defined, 3 back-to-back frames at one sample/cycle -> in_ready never drops; 12 groups out in frame order.

Source files
------------

// File: rtl/radix4_feeder.sv
// radix4_feeder: collects 16-sample complex frames and issues them as four
// radix-4 butterfly groups (A,B,C,D = x[k], x[k+4], x[k+8], x[k+12]) with
// their twiddles W^k, W^2k, W^3k from a constant ROM (8.8 at NBITS=16).
// Optional feature: define RADIX4_FEEDER_PINGPONG_EN for a two-bank buffer
// that fills one bank while the other issues (default: single bank).
module radix4_feeder #(
  parameter int NBITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NBITS-1:0] in_re,
  input  logic signed [NBITS-1:0] in_im,
  output logic                    out_valid,
  output logic                    out_first,
  output logic signed [NBITS-1:0] Ar,
  output logic signed [NBITS-1:0] Ai,
  output logic signed [NBITS-1:0] Br,
  output logic signed [NBITS-1:0] Bi,
  output logic signed [NBITS-1:0] Cr,
  output logic signed [NBITS-1:0] Ci,
  output logic signed [NBITS-1:0] Dr,
  output logic signed [NBITS-1:0] Di,
  output logic signed [NBITS-1:0] WBr,
  output logic signed [NBITS-1:0] WBi,
  output logic signed [NBITS-1:0] WCr,
  output logic signed [NBITS-1:0] WCi,
  output logic signed [NBITS-1:0] WDr,
  output logic signed [NBITS-1:0] WDi
);

  // cos(2*pi*m/16) scaled by 256; sin is the same table shifted by a quarter turn
  function automatic logic signed [NBITS-1:0] cos_q(input logic [3:0] m);
    int v;
    v = 0;
    case (m)
      4'd0:  v = 256;
      4'd1:  v = 237;
      4'd2:  v = 181;
      4'd3:  v = 98;
      4'd4:  v = 0;
      4'd5:  v = -98;
      4'd6:  v = -181;
      4'd7:  v = -237;
      4'd8:  v = -256;
      4'd9:  v = -237;
      4'd10: v = -181;
      4'd11: v = -98;
      4'd12: v = 0;
      4'd13: v = 98;
      4'd14: v = 181;
      4'd15: v = 237;
    endcase
    return NBITS'(v);
  endfunction

  function automatic logic signed [NBITS-1:0] sin_q(input logic [3:0] m);
    return cos_q(m - 4'd4);
  endfunction

  logic       rdy_q;
  logic [3:0] wr_cnt;
  logic [1:0] iss_cnt;
  logic       issue_en;
  logic       xfer;

`ifdef RADIX4_FEEDER_PINGPONG_EN
  localparam int AW = 5;
  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
`else
  localparam int AW = 4;
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0] state;
`endif

  logic [AW-1:0] wr_addr, a_addr, b_addr, c_addr, d_addr;
  logic signed [NBITS-1:0] mem_re [0:(1<<AW)-1];
  logic signed [NBITS-1:0] mem_im [0:(1<<AW)-1];
  logic [3:0] e1, e2, e3;

  assign xfer = in_valid && in_ready;
  assign e1   = {2'b00, iss_cnt};
  assign e2   = {1'b0, iss_cnt, 1'b0};
  assign e3   = e1 + e2;

  // ready is held low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

`ifdef RADIX4_FEEDER_PINGPONG_EN
  assign wr_addr  = {wr_bank, wr_cnt};
  assign a_addr   = {rd_bank, 2'd0, iss_cnt};
  assign b_addr   = {rd_bank, 2'd1, iss_cnt};
  assign c_addr   = {rd_bank, 2'd2, iss_cnt};
  assign d_addr   = {rd_bank, 2'd3, iss_cnt};
  assign issue_en = full[rd_bank];
  assign in_ready = rdy_q && !full[wr_bank];

  // bank bookkeeping: a bank is marked full by its 16th sample and freed after group 3;
  // the write bank is never full when written, so set and clear never hit the same bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 4'd0;
      iss_cnt <= 2'd0;
    end else begin
      if (xfer) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_cnt == 4'd15) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (issue_en) begin
        iss_cnt <= iss_cnt + 2'd1;
        if (iss_cnt == 2'd3) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end
`else
  assign wr_addr  = wr_cnt;
  assign a_addr   = {2'd0, iss_cnt};
  assign b_addr   = {2'd1, iss_cnt};
  assign c_addr   = {2'd2, iss_cnt};
  assign d_addr   = {2'd3, iss_cnt};
  assign issue_en = (state == ISSUE);
  assign in_ready = rdy_q && (state == FILL);

  // FILL accepts 16 samples, ISSUE then emits four groups back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      wr_cnt  <= 4'd0;
      iss_cnt <= 2'd0;
    end else begin
      if (xfer) wr_cnt <= wr_cnt + 4'd1;
      case (state)
        FILL: if (xfer && wr_cnt == 4'd15) state <= ISSUE;
        ISSUE: begin
          iss_cnt <= iss_cnt + 2'd1;
          if (iss_cnt == 2'd3) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
`endif

  // sample buffer write; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_re[wr_addr] <= in_re;
      mem_im[wr_addr] <= in_im;
    end
  end

  // output stage: register one group per issue cycle, hold values otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      Ar  <= '0; Ai  <= '0; Br  <= '0; Bi  <= '0;
      Cr  <= '0; Ci  <= '0; Dr  <= '0; Di  <= '0;
      WBr <= '0; WBi <= '0; WCr <= '0; WCi <= '0;
      WDr <= '0; WDi <= '0;
    end else if (issue_en) begin
      out_valid <= 1'b1;
      out_first <= (iss_cnt == 2'd0);
      Ar  <= mem_re[a_addr]; Ai <= mem_im[a_addr];
      Br  <= mem_re[b_addr]; Bi <= mem_im[b_addr];
      Cr  <= mem_re[c_addr]; Ci <= mem_im[c_addr];
      Dr  <= mem_re[d_addr]; Di <= mem_im[d_addr];
      WBr <= cos_q(e1); WBi <= -sin_q(e1);
      WCr <= cos_q(e2); WCi <= -sin_q(e2);
      WDr <= cos_q(e3); WDi <= -sin_q(e3);
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radix4_feeder.sv
// Bench for radix4_feeder: table of known groups for a ramp frame, a
// scoreboard fed by a frame model for streamed/random/reset sequences.
module tb_radix4_feeder;

  localparam real PI = 3.14159265358979;
`ifdef RADIX4_FEEDER_PINGPONG_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 4;
`endif

  typedef struct packed {
    logic signed [15:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [15:0] wbr, wbi, wcr, wci, wdr, wdi;
    logic               first;
  } grp_t;

  typedef struct {
    int   k;
    grp_t exp;
  } vec_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_first;
  logic signed [15:0] in_re, in_im;
  logic signed [15:0] Ar, Ai, Br, Bi, Cr, Ci, Dr, Di;
  logic signed [15:0] WBr, WBi, WCr, WCi, WDr, WDi;

  int nchk = 0, npass = 0, nfail = 0;
  grp_t sb[$];
  logic signed [15:0] mre [16];
  logic signed [15:0] mim [16];
  int mcnt = 0;
  vec_t tbl [4];

  radix4_feeder #(.NBITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_first(out_first),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi), .Cr(Cr), .Ci(Ci), .Dr(Dr), .Di(Di),
    .WBr(WBr), .WBi(WBi), .WCr(WCr), .WCi(WCi), .WDr(WDr), .WDi(WDi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_i(input string nm, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_g(input string nm, input grp_t got, input grp_t exp);
    nchk++;
    if (got == exp) npass++;
    else begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic grp_t dut_grp();
    grp_t g;
    g = {Ar, Ai, Br, Bi, Cr, Ci, Dr, Di, WBr, WBi, WCr, WCi, WDr, WDi, out_first};
    return g;
  endfunction

  function automatic grp_t mk(input int a, b, c, d, wbr, wbi, wcr, wci, wdr, wdi,
                              input logic f);
    grp_t g;
    g = '0;
    g.ar = 16'(a); g.br = 16'(b); g.cr = 16'(c); g.dr = 16'(d);
    g.wbr = 16'(wbr); g.wbi = 16'(wbi);
    g.wcr = 16'(wcr); g.wci = 16'(wci);
    g.wdr = 16'(wdr); g.wdi = 16'(wdi);
    g.first = f;
    return g;
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic logic signed [15:0] twr(input int m);
    return 16'(rnd(256.0 * $cos(2.0 * PI * m / 16.0)));
  endfunction

  function automatic logic signed [15:0] twi(input int m);
    return 16'(-rnd(256.0 * $sin(2.0 * PI * m / 16.0)));
  endfunction

  // model: collect accepted samples, expand a complete frame into 4 groups
  task automatic model_accept(input logic signed [15:0] re, input logic signed [15:0] im);
    grp_t g;
    mre[mcnt] = re;
    mim[mcnt] = im;
    mcnt++;
    if (mcnt == 16) begin
      for (int k = 0; k < 4; k++) begin
        g.ar = mre[k];      g.ai = mim[k];
        g.br = mre[k + 4];  g.bi = mim[k + 4];
        g.cr = mre[k + 8];  g.ci = mim[k + 8];
        g.dr = mre[k + 12]; g.di = mim[k + 12];
        g.wbr = twr(k);           g.wbi = twi(k);
        g.wcr = twr((2 * k) % 16); g.wci = twi((2 * k) % 16);
        g.wdr = twr((3 * k) % 16); g.wdi = twi((3 * k) % 16);
        g.first = (k == 0);
        sb.push_back(g);
      end
      mcnt = 0;
    end
  endtask

  task automatic cycle(input logic v, input logic signed [15:0] re,
                       input logic signed [15:0] im, output logic acc);
    @(negedge clk);
    in_valid = v; in_re = re; in_im = im;
    #1;
    acc = v && in_ready;
    if (acc) model_accept(re, im);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'sd0, 16'sd0, a);
  endtask

  task automatic stream(input int nfr);
    int acc_n, low, cyc;
    logic a;
    acc_n = 0; low = 0; cyc = 0;
    while (acc_n < 16 * nfr && cyc < 64 * nfr) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), a);
      cyc++;
      if (a) begin
        if (low != 0) chk_i("stall_len", low, EXP_STALL);
        low = 0;
        acc_n++;
      end else low++;
    end
    chk_i("stream_done", acc_n, 16 * nfr);
  endtask

  // scoreboard: every valid group must match the next expected one
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL sb_extra got=%h exp=none", dut_grp());
      end else begin
        chk_g("sb_grp", dut_grp(), sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    tbl[0] = '{0, mk(0,   1024, 2048, 3072, 256, 0,    256,  0,    256,  0,    1'b1)};
    tbl[1] = '{1, mk(256, 1280, 2304, 3328, 237, -98,  181,  -181, 98,   -237, 1'b0)};
    tbl[2] = '{2, mk(512, 1536, 2560, 3584, 181, -181, 0,    -256, -181, -181, 1'b0)};
    tbl[3] = '{3, mk(768, 1792, 2816, 3840, 98,  -237, -181, -181, -237, 98,   1'b0)};

    rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
    #3;
    chk_g("rst_outs", dut_grp(), '0);
    chk_i("rst_valid", int'({out_valid, out_first}), 0);
    chk_i("rst_ready", int'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_i("ready_after_rst", int'(in_ready), 1);

    // ramp frame x[n] = n*256 checked against the known-group table
    for (int n = 0; n < 16; n++) cycle(1'b1, 16'(n * 256), 16'sd0, a);
    @(negedge clk);
    in_valid = 1'b0;
    chk_i("lat_no_valid", int'(out_valid), 0);
    chk_i("ready_in_issue", int'(in_ready), (EXP_STALL != 0) ? 0 : 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_i("tbl_valid", int'(out_valid), 1);
      chk_g($sformatf("tbl_k%0d", tbl[i].k), dut_grp(), tbl[i].exp);
    end
    idle(2);
    chk_i("hold_valid", int'(out_valid), 0);
    chk_g("hold_vals", dut_grp(), tbl[3].exp);

    // continuous stream: single bank stalls for the issue cycles, two banks never
    stream(3);
    idle(8);

    // reset mid-fill discards the partial frame
    for (int n = 0; n < 9; n++) cycle(1'b1, 16'($urandom), 16'($urandom), a);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_g("async_rst_outs", dut_grp(), '0);
    chk_i("async_rst_valid", int'(out_valid), 0);
    chk_i("async_rst_ready", int'(in_ready), 0);
    sb.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_i("ready_after_rst2", int'(in_ready), 1);
    for (int n = 0; n < 16; n++) cycle(1'b1, 16'($urandom), 16'($urandom), a);
    idle(8);

    // random valid toggling: groups depend only on accepted samples
    for (int n = 0; n < 120; n++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), a);
    idle(10);

    chk_i("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
